// File: rtl/fetch_pkg.sv
// Shared fetch-path types and sizes, used by the fetch unit, fetch queue and decode.
package fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FQ_DEPTH = 4;

  // One fetch queue slot: the fetched address, its instruction word, and whether
  // the instruction word has come back from imem yet.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_store.sv
// Entry storage for the fetch queue: one alloc port, one fill port, one release
// port, a bulk flush of the filled bits, and one asynchronous read port.
module fetch_queue_store
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alloc_en_i,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx_i,
  input  logic [XLEN-1:0]          alloc_pc_i,
  input  logic                     fill_en_i,
  input  logic [$clog2(DEPTH)-1:0] fill_idx_i,
  input  logic [XLEN-1:0]          fill_inst_i,
  input  logic                     release_en_i,
  input  logic [$clog2(DEPTH)-1:0] release_idx_i,
  input  logic                     flush_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output fetch_entry_t             rd_entry_c_o
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  // Next contents: flush/release clear filled, then alloc, then fill on top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (flush_i) begin
        mem_d[i].filled = 1'b0;
      end
    end
    if (release_en_i) begin
      mem_d[release_idx_i].filled = 1'b0;
    end
    if (alloc_en_i) begin
      mem_d[alloc_idx_i].pc     = alloc_pc_i;
      mem_d[alloc_idx_i].inst   = '0;
      mem_d[alloc_idx_i].filled = 1'b0;
    end
    if (fill_en_i) begin
      mem_d[fill_idx_i].inst   = fill_inst_i;
      mem_d[fill_idx_i].filled = 1'b1;
    end
  end

  // Entry array register; reset wipes pc, inst and filled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_entry_c_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between the fetch unit and decode: issues imem requests under a
// credit limit, collects in-order responses, and hands instructions to decode.
// Responses still owed for requests killed by a flush are counted and dropped.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned XLEN  = fetch_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_pc,
  input  logic            io_flush,
  output logic            io_stall,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [XLEN-1:0] io_imem_resp_data,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_pc,
  output logic [XLEN-1:0] io_out_inst
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = fetch_pkg::XLEN;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          running_q;

  fetch_entry_t  head_entry;
  logic [AW-1:0] fill_dist;
  logic [CW-1:0] filled_cnt;
  logic [CW-1:0] owed_cnt;
  logic          credit_ok;
  logic          req_fire;
  logic          out_fire;
  logic          resp_stale;
  logic          resp_fill;
  logic          resp_taken;

  // Handshakes, response classification and pointer/counter next state.
  always_comb begin
    head_d      = head_q;
    fill_d      = fill_q;
    tail_d      = tail_q;
    alloc_cnt_d = alloc_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    // Filled entries sit between head and fill; equal pointers with a filled
    // head can only mean the whole ring is allocated and filled.
    fill_dist  = fill_q - head_q;
    filled_cnt = {1'b0, fill_dist};
    if (fill_dist == '0 && head_entry.filled) begin
      filled_cnt = CW'(DEPTH);
    end
    owed_cnt = alloc_cnt_q - filled_cnt;

    credit_ok         = ({1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q}) < (CW + 1)'(DEPTH);
    io_imem_req_valid = running_q && !io_flush && credit_ok;
    req_fire          = io_imem_req_valid && io_imem_req_ready;
    io_stall          = !req_fire;

    io_out_valid = head_entry.filled && !io_flush;
    out_fire     = io_out_valid && io_out_ready;

    resp_stale = io_imem_resp_valid && (drop_cnt_q != '0);
    resp_fill  = io_imem_resp_valid && (drop_cnt_q == '0) && (owed_cnt != '0) && !io_flush;
    resp_taken = io_imem_resp_valid && ((drop_cnt_q != '0) || (owed_cnt != '0));

    if (io_flush) begin
      head_d      = tail_q;
      fill_d      = tail_q;
      alloc_cnt_d = '0;
      drop_cnt_d  = drop_cnt_q + owed_cnt - CW'(resp_taken);
    end else begin
      if (resp_stale) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (resp_fill) begin
        fill_d = fill_q + AW'(1);
      end
      if (out_fire) begin
        head_d = head_q + AW'(1);
      end
      if (req_fire) begin
        tail_d = tail_q + AW'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CW'(req_fire) - CW'(out_fire);
    end
  end

  // Pointer and counter registers; running_q holds requests off until the
  // first clock edge after reset is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      fill_q      <= '0;
      tail_q      <= '0;
      alloc_cnt_q <= '0;
      drop_cnt_q  <= '0;
      running_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      fill_q      <= fill_d;
      tail_q      <= tail_d;
      alloc_cnt_q <= alloc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      running_q   <= 1'b1;
    end
  end

  fetch_queue_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .clock         (clock),
    .reset         (reset),
    .alloc_en_i    (req_fire),
    .alloc_idx_i   (tail_q),
    .alloc_pc_i    (EW'(io_pc)),
    .fill_en_i     (resp_fill),
    .fill_idx_i    (fill_q),
    .fill_inst_i   (EW'(io_imem_resp_data)),
    .release_en_i  (out_fire),
    .release_idx_i (head_q),
    .flush_i       (io_flush),
    .rd_idx_i      (head_q),
    .rd_entry_c_o  (head_entry)
  );

  assign io_imem_req_addr = io_pc;
  assign io_out_pc        = XLEN'(head_entry.pc);
  assign io_out_inst      = XLEN'(head_entry.inst);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic, checked
// against a queue-based model of the fetch queue and an in-order imem model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [XLEN-1:0] io_pc = '0;
  logic            io_flush = 1'b0;
  logic            io_stall;
  logic            io_imem_req_valid;
  logic            io_imem_req_ready = 1'b0;
  logic [XLEN-1:0] io_imem_req_addr;
  logic            io_imem_resp_valid = 1'b0;
  logic [XLEN-1:0] io_imem_resp_data = '0;
  logic            io_out_valid;
  logic            io_out_ready = 1'b0;
  logic [XLEN-1:0] io_out_pc;
  logic [XLEN-1:0] io_out_inst;

  always #5 clock = ~clock;

  fetch_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_pc              (io_pc),
    .io_flush           (io_flush),
    .io_stall           (io_stall),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_pc          (io_out_pc),
    .io_out_inst        (io_out_inst)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ment_t;

  typedef struct {
    logic [31:0] data;
    int          issue;
  } imem_t;

  // Model state: live queue entries, stale responses owed, imem pipe.
  ment_t       q[$];
  imem_t       imem[$];
  int          owed;
  bit          running;
  int          cyc;
  bit          ovr_en;
  logic [31:0] ovr_data;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic step(input logic [31:0] pc, input bit fl, input bit rr, input bit orr,
                      input bit rsp, input bit spur);
    bit    from_imem;
    bit    rv;
    bit    exp_req;
    bit    exp_outv;
    bit    req_fire;
    bit    out_fire;
    int    unfilled;
    int    take;
    imem_t ie;
    ment_t me;
    logic [31:0] rdata;

    io_pc             = pc;
    io_flush          = fl;
    io_imem_req_ready = rr;
    io_out_ready      = orr;
    from_imem = rsp && (imem.size() > 0) && (imem[0].issue < cyc);
    rv        = from_imem || (spur && imem.size() == 0);
    rdata     = from_imem ? imem[0].data : 32'($urandom);
    io_imem_resp_valid = rv;
    io_imem_resp_data  = rdata;
    #1;

    exp_req  = running && !fl && ((q.size() + owed) < DEPTH);
    req_fire = exp_req && rr;
    exp_outv = !fl && (q.size() > 0) && q[0].filled;
    out_fire = exp_outv && orr;

    chk("req_valid", 32'(io_imem_req_valid), 32'(exp_req));
    chk("stall", 32'(io_stall), 32'(!req_fire));
    chk("out_valid", 32'(io_out_valid), 32'(exp_outv));
    if (exp_req) chk("req_addr", io_imem_req_addr, pc);
    if (exp_outv) begin
      chk("out_pc", io_out_pc, q[0].pc);
      chk("out_inst", io_out_inst, q[0].inst);
    end

    @(posedge clock);
    #1;

    unfilled = 0;
    foreach (q[i]) if (!q[i].filled) unfilled++;

    if (fl) begin
      take = (rv && (owed + unfilled) > 0) ? 1 : 0;
      owed = owed + unfilled - take;
      q.delete();
    end else begin
      if (rv) begin
        if (owed > 0) begin
          owed--;
        end else begin
          for (int i = 0; i < q.size(); i++) begin
            if (!q[i].filled) begin
              q[i].inst   = rdata;
              q[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (out_fire) void'(q.pop_front());
      if (req_fire) begin
        me.pc = pc; me.inst = '0; me.filled = 1'b0;
        q.push_back(me);
      end
    end

    if (from_imem) void'(imem.pop_front());
    if (req_fire) begin
      ie.data  = ovr_en ? ovr_data : 32'($urandom);
      ie.issue = cyc;
      imem.push_back(ie);
    end
    running = 1'b1;
    cyc++;
  endtask

  // Assert reset (imem pipe dropped with it), check held outputs, release off-edge.
  task automatic do_reset();
    reset              = 1'b0;
    io_flush           = 1'b0;
    io_imem_resp_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(io_out_valid), 32'd0);
    chk("rst_out_pc", io_out_pc, 32'd0);
    chk("rst_out_inst", io_out_inst, 32'd0);
    chk("rst_req_valid", 32'(io_imem_req_valid), 32'd0);
    chk("rst_stall", 32'(io_stall), 32'd1);
    q.delete();
    imem.delete();
    owed    = 0;
    running = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; owed = 0; running = 1'b0; cyc = 0;
    ovr_en = 1'b0; ovr_data = '0;

    @(posedge clock);
    #1;
    do_reset();
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single fetch of 0x100 returning 0x13.
    ovr_en = 1'b1; ovr_data = 32'h0000_0013;
    step(32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ovr_en = 1'b0;
    step(32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Full stall with decode blocked, then one pop frees a credit.
    step(32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'hC,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Flush with two requests in flight; their responses must be dropped.
    step(32'h20,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h24,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h28,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h400, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(32'h404, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(32'h408, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(32'h408, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Response arriving in the flush cycle plus one owed afterwards.
    step(32'h20,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h24,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h28,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h2C,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(32'h500, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(32'h504, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Back-to-back fetches wrapping the ring pointers.
    for (int i = 0; i < 10; i++) step(32'(i * 4), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset mid-run with three entries filled.
    step(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h48, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h4C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    step(32'h800, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h800, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Spurious responses with nothing outstanding are ignored.
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(32'($urandom_range(0, 16383)) << 2,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 29) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries and maximum in-flight requests; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32, meaning address and instruction width.
REQ-003 SHALL have port clock  input  1  meaning the single clock.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port io_pc  input  XLEN  meaning the current PC from the fetch unit.
REQ-006 SHALL have port io_flush  input  1  meaning redirect; it is the same signal as the fetch unit's npc-load control.
REQ-007 SHALL have port io_stall  output  1  meaning hold the PC; it drives the fetch unit's hold control.
REQ-008 SHALL have ports io_imem_req_valid (output, 1), io_imem_req_ready (input, 1) and io_imem_req_addr (output, XLEN), forming the imem request handshake.
REQ-009 SHALL have ports io_imem_resp_valid (input, 1) and io_imem_resp_data (input, XLEN), forming the imem response channel: in-order, latency at least 1 cycle, no backpressure.
REQ-010 SHALL have ports io_out_valid (output, 1), io_out_ready (input, 1), io_out_pc (output, XLEN) and io_out_inst (output, XLEN), forming the decode handshake.

Function
REQ-011 SHALL keep a ring of DEPTH entries, each holding {pc, inst, filled}, with head, fill and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-012 SHALL keep alloc_cnt (entries allocated) and drop_cnt (stale responses still owed), each log2(DEPTH)+1 bits.
REQ-013 SHALL drive io_imem_req_valid = !io_flush && (alloc_cnt + drop_cnt < DEPTH); io_imem_req_addr = io_pc.
REQ-014 SHALL, on a request fire (valid && ready), allocate the tail entry with pc = io_pc and filled = 0, then advance the tail.
REQ-015 SHALL drive io_stall = !(io_imem_req_valid && io_imem_req_ready), so the PC advances only on an accepted request.
REQ-016 SHALL, on io_imem_resp_valid with drop_cnt > 0, discard the data and decrement drop_cnt.
REQ-017 SHALL, on io_imem_resp_valid with drop_cnt = 0, write inst into the fill entry, set filled, and advance the fill pointer.
REQ-018 SHALL ignore io_imem_resp_valid when nothing is outstanding; this is a protocol violation, and state SHALL be unchanged.
REQ-019 SHALL drive io_out_valid = head.filled && !io_flush; io_out_pc and io_out_inst come from the head entry.
REQ-020 SHALL, on an output fire, release the head, advance the head, and decrement alloc_cnt.
REQ-021 SHALL give latency: request fire in cycle N, response earliest N+1, io_out_valid earliest N+2.
REQ-022 SHALL, on io_flush, clear all filled bits, set head = fill = tail, set alloc_cnt = 0, and set drop_cnt = drop_cnt + (outstanding unreturned) - (stale-counted response this cycle).
REQ-023 SHALL treat a response arriving in the flush cycle as pre-flush, counting it against the owed total and discarding it.
REQ-024 SHALL give flush priority over a same-cycle output handshake (no fire) and a request (suppressed).
REQ-025 SHALL allow a request, a response and an output fire in the same cycle, with alloc_cnt net-updated.
REQ-026 SHALL stop requests when full (alloc_cnt + drop_cnt = DEPTH), forcing io_stall = 1.
REQ-027 SHALL allow requests while drop_cnt > 0, with the credit limit per REQ-013.

Reset
REQ-028 SHALL, while reset = 0, asynchronously clear all pointers, counters, filled bits, and the pc and inst storage.
REQ-029 SHALL, during reset, hold io_out_valid = 0, io_out_pc = 0, io_out_inst = 0, io_imem_req_valid = 0 and io_stall = 1.
REQ-030 SHALL, on the first edge after reset deassertion with io_flush = 0, allow io_imem_req_valid = 1.
REQ-031 SHALL, on reset asserted mid-operation, lose in-flight requests with no drop accounting; the bench SHALL reset imem concurrently.

Structure
REQ-032 SHALL place XLEN, FQ_DEPTH and the fetch entry struct {pc, inst, filled} in shared package fetch_pkg, reused by the fetch unit and decode.
REQ-033 SHALL use one sub-module, fetch_queue_store: a DEPTH x entry array with separate alloc, fill and read ports; the control stays in fetch_queue.
REQ-034 SHALL be 120-400 lines of RTL total.

Verification
REQ-035 SHALL cover single fetch: io_pc = 0x100, ready = 1, response 0x00000013 one cycle later -> io_out_valid two cycles after the request, io_out_pc = 0x100, io_out_inst = 0x13.
REQ-036 SHALL cover full stall: DEPTH = 4, io_out_ready = 0, requests 0x0/0x4/0x8/0xC all responded -> fifth cycle io_imem_req_valid = 0, io_stall = 1; one output pop -> request 0x10 issued the next cycle.
REQ-037 SHALL cover flush with 2 in flight: requests 0x20 and 0x24 outstanding, io_flush pulse, io_pc = 0x400 -> next two responses discarded, first output io_out_pc = 0x400.
REQ-038 SHALL cover simultaneous events: a response for 0x24 in the flush cycle plus one later -> drop_cnt goes 0 to 1 to 0, neither response is visible at the output.
REQ-039 SHALL cover wrap-around: 10 back-to-back fetches with io_out_ready = 1, 1-cycle imem -> io_out_pc sequence 0x0..0x24 step 4, no gaps after fill, pointers wrap twice.
REQ-040 SHALL cover reset mid-run: reset low with 3 entries filled -> io_out_valid = 0 immediately (asynchronous); after release, the first request presents the current io_pc.
